// File: rtl/vector_scalar_divider.sv
// Nine-lane 16-bit by 8-bit sequential divider built on one shared restoring stage.
// Optional per-lane inexact flags are built when VECTOR_DIVIDER_INEXACT_EN is defined.
module vector_scalar_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  input  logic [15:0] in8,
  input  logic [15:0] in9,
  input  logic [7:0]  scalar,
  output logic        busy,
  output logic        done,
  output logic [15:0] q1,
  output logic [15:0] q2,
  output logic [15:0] q3,
  output logic [15:0] q4,
  output logic [15:0] q5,
  output logic [15:0] q6,
  output logic [15:0] q7,
  output logic [15:0] q8,
  output logic [15:0] q9,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [7:0]  r3,
  output logic [7:0]  r4,
  output logic [7:0]  r5,
  output logic [7:0]  r6,
  output logic [7:0]  r7,
  output logic [7:0]  r8,
  output logic [7:0]  r9,
  output logic        div0,
  output logic [8:0]  inexact
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one restoring step per cycle, lanes 1..9
  // DONE  | one-cycle result pulse; start here begins the next run
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] dvd [9];
  logic [7:0]  divisor;
  logic [7:0]  rem;
  logic [3:0]  lane_idx;
  logic [3:0]  bit_idx;
  logic [14:0] q_acc;
  logic [15:0] q_arr [9];
  logic [7:0]  r_arr [9];

  logic [15:0] cur_dvd;
  logic [8:0]  t;
  logic [8:0]  diff;
  logic        ge;
  logic [7:0]  rem_next;
  logic [15:0] q_next;
  logic        accept;
  logic        lane_done;

  always_comb begin
    cur_dvd  = dvd[lane_idx];
    t        = {rem, cur_dvd[bit_idx]};
    diff     = t - {1'b0, divisor};
    ge       = (t >= {1'b0, divisor});
    rem_next = ge ? diff[7:0] : t[7:0];
    q_next   = {q_acc, ge};
  end

  assign accept    = start && (state != CALC);
  assign lane_done = (state == CALC) && (divisor != 8'd0) && (bit_idx == 4'd0);

  // A zero divisor still spends one CALC cycle so DONE lands one edge after accept.
  assign busy = (state == CALC) && (divisor != 8'd0);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      divisor  <= 8'd0;
      rem      <= 8'd0;
      lane_idx <= 4'd0;
      bit_idx  <= 4'd0;
      q_acc    <= 15'd0;
      div0     <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        dvd[i]   <= 16'd0;
        q_arr[i] <= 16'd0;
        r_arr[i] <= 8'd0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dvd[0]   <= in1;
            dvd[1]   <= in2;
            dvd[2]   <= in3;
            dvd[3]   <= in4;
            dvd[4]   <= in5;
            dvd[5]   <= in6;
            dvd[6]   <= in7;
            dvd[7]   <= in8;
            dvd[8]   <= in9;
            divisor  <= scalar;
            div0     <= 1'b0;
            lane_idx <= 4'd0;
            bit_idx  <= 4'd15;
            rem      <= 8'd0;
            q_acc    <= 15'd0;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (divisor == 8'd0) begin
            for (int i = 0; i < 9; i++) begin
              q_arr[i] <= 16'hFFFF;
              r_arr[i] <= 8'd0;
            end
            div0  <= 1'b1;
            state <= DONE;
          end else if (lane_done) begin
            q_arr[lane_idx] <= q_next;
            r_arr[lane_idx] <= rem_next;
            rem     <= 8'd0;
            q_acc   <= 15'd0;
            bit_idx <= 4'd15;
            if (lane_idx == 4'd8) begin
              state <= DONE;
            end else begin
              lane_idx <= lane_idx + 4'd1;
            end
          end else begin
            rem     <= rem_next;
            q_acc   <= q_next[14:0];
            bit_idx <= bit_idx - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VECTOR_DIVIDER_INEXACT_EN
  logic [8:0] inexact_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_q <= 9'd0;
    end else if (accept) begin
      inexact_q <= 9'd0;
    end else if (lane_done && ((rem_next != 8'd0) || (q_next[15:8] != 8'd0))) begin
      inexact_q[lane_idx] <= 1'b1;
    end
  end

  assign inexact = inexact_q;
`else
  assign inexact = 9'd0;
`endif

  assign q1 = q_arr[0];
  assign q2 = q_arr[1];
  assign q3 = q_arr[2];
  assign q4 = q_arr[3];
  assign q5 = q_arr[4];
  assign q6 = q_arr[5];
  assign q7 = q_arr[6];
  assign q8 = q_arr[7];
  assign q9 = q_arr[8];
  assign r1 = r_arr[0];
  assign r2 = r_arr[1];
  assign r3 = r_arr[2];
  assign r4 = r_arr[3];
  assign r5 = r_arr[4];
  assign r6 = r_arr[5];
  assign r7 = r_arr[6];
  assign r8 = r_arr[7];
  assign r9 = r_arr[8];

endmodule

// File: tb/tb_vector_scalar_divider.sv
// Directed bench for vector_scalar_divider; results compared against plain / and % arithmetic.
module tb_vector_scalar_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_v [9];
  logic [7:0]  scalar_v = 8'd0;
  logic        busy, done, div0;
  logic [15:0] q_o [9];
  logic [7:0]  r_o [9];
  logic [8:0]  inexact;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [9];
  logic [7:0]  exp_r [9];
  logic        exp_div0 = 1'b0;
  logic [8:0]  exp_inex = 9'd0;

  vector_scalar_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in_v[0]), .in2(in_v[1]), .in3(in_v[2]), .in4(in_v[3]), .in5(in_v[4]),
    .in6(in_v[5]), .in7(in_v[6]), .in8(in_v[7]), .in9(in_v[8]),
    .scalar(scalar_v), .busy(busy), .done(done),
    .q1(q_o[0]), .q2(q_o[1]), .q3(q_o[2]), .q4(q_o[3]), .q5(q_o[4]),
    .q6(q_o[5]), .q7(q_o[6]), .q8(q_o[7]), .q9(q_o[8]),
    .r1(r_o[0]), .r2(r_o[1]), .r3(r_o[2]), .r4(r_o[3]), .r5(r_o[4]),
    .r6(r_o[5]), .r7(r_o[6]), .r8(r_o[7]), .r9(r_o[8]),
    .div0(div0), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Model: expected results for the data captured on the accepting edge.
  task automatic set_exp();
    exp_div0 = (scalar_v == 8'd0);
    for (int i = 0; i < 9; i++) begin
      if (scalar_v == 8'd0) begin
        exp_q[i] = 16'hFFFF;
        exp_r[i] = 8'd0;
      end else begin
        exp_q[i] = in_v[i] / {8'd0, scalar_v};
        exp_r[i] = 8'(in_v[i] % {8'd0, scalar_v});
      end
`ifdef VECTOR_DIVIDER_INEXACT_EN
      exp_inex[i] = (scalar_v != 8'd0) && ((exp_r[i] != 8'd0) || (exp_q[i] > 16'd255));
`else
      exp_inex[i] = 1'b0;
`endif
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("q%0d", i + 1), 32'(q_o[i]), 32'(exp_q[i]));
        chk($sformatf("r%0d", i + 1), 32'(r_o[i]), 32'(exp_r[i]));
      end
      chk("div0", 32'(div0), 32'(exp_div0));
      chk("inexact", 32'(inexact), 32'(exp_inex));
    end
  end

  task automatic set_lanes(input int base, input int step, input logic [7:0] s);
    for (int i = 0; i < 9; i++) in_v[i] = 16'(base + step * (i + 1));
    scalar_v = s;
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    set_exp();
    #1;
    chk("busy_after_accept", 32'(busy), 32'(!exp_div0));
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int lat, input int inject_at, input int abort_at);
    int n = 0;
    int busy_bad = 0;
    logic any;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (n == abort_at) begin
        #1;
        rst = 1'b1;
        #1;
        any = busy | done | div0 | (|inexact);
        for (int i = 0; i < 9; i++) any = any | (|q_o[i]) | (|r_o[i]);
        chk("async_reset_outputs", 32'(any), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 32'(busy | done), 32'd0);
        return;
      end
      if (busy !== (!exp_div0 && n < lat)) busy_bad++;
      if (n == inject_at) begin
        start = 1'b1;
        set_lanes(4000, 3, 8'd3);
      end
      if (n == inject_at + 1) start = 1'b0;
      if (done === 1'b1) break;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("busy_profile", 32'(busy_bad), 32'd0);
  endtask

  task automatic pulse_end();
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    set_lanes(0, 0, 8'd0);
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q1", 32'(q_o[0]), 32'd0);
    chk("reset_r9", 32'(r_o[8]), 32'd0);
    chk("reset_div0_inexact", 32'({div0, inexact}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exact recovery: lane 1 = 255*6, lane k = 37k.
    set_lanes(0, 37, 8'd6);
    in_v[0] = 16'd1530;
    launch(1'b0);
    wait_done(144, -1, -1);
    chk("t1_q1", 32'(q_o[0]), 32'd255);
    chk("t1_r1", 32'(r_o[0]), 32'd0);
    chk("t1_q2", 32'(q_o[1]), 32'd12);
    chk("t1_r2", 32'(r_o[1]), 32'd2);
    chk("t1_q6", 32'(q_o[5]), 32'd37);
`ifdef VECTOR_DIVIDER_INEXACT_EN
    chk("t1_inexact", 32'(inexact), 32'h1DE);
`else
    chk("t1_inexact", 32'(inexact), 32'd0);
`endif
    pulse_end();

    // Inexact lane.
    set_lanes(0, 700, 8'd7);
    in_v[0] = 16'd100;
    launch(1'b0);
    wait_done(144, -1, -1);
    chk("t2_q1", 32'(q_o[0]), 32'd14);
    chk("t2_r1", 32'(r_o[0]), 32'd2);
`ifdef VECTOR_DIVIDER_INEXACT_EN
    chk("t2_inexact0", 32'(inexact[0]), 32'd1);
`else
    chk("t2_inexact0", 32'(inexact[0]), 32'd0);
`endif
    pulse_end();

    // Quotient wider than 8 bits.
    set_lanes(0, 200, 8'd1);
    in_v[0] = 16'hFFFF;
    launch(1'b0);
    wait_done(144, -1, -1);
    chk("t3_q1", 32'(q_o[0]), 32'hFFFF);
    chk("t3_r1", 32'(r_o[0]), 32'd0);
`ifdef VECTOR_DIVIDER_INEXACT_EN
    chk("t3_inexact0", 32'(inexact[0]), 32'd1);
`endif
    pulse_end();

    // Divide by zero.
    set_lanes(11, 5, 8'd0);
    launch(1'b0);
    wait_done(1, -1, -1);
    chk("t4_div0", 32'(div0), 32'd1);
    chk("t4_q5", 32'(q_o[4]), 32'hFFFF);
    chk("t4_r9", 32'(r_o[8]), 32'd0);
    pulse_end();
    chk("t4_div0_holds", 32'(div0), 32'd1);

    // Start during busy must be ignored.
    set_lanes(1, 1001, 8'd13);
    launch(1'b0);
    wait_done(144, 50, -1);
    chk("t5_div0_cleared", 32'(div0), 32'd0);
    pulse_end();

    // Reset mid-run, then a fresh run.
    set_lanes(500, 6000, 8'd250);
    launch(1'b0);
    wait_done(144, -1, 70);
    set_lanes(17, 7000, 8'd250);
    launch(1'b0);
    wait_done(144, -1, -1);
    pulse_end();

    // Back-to-back: start held through DONE begins the next run with no gap.
    set_lanes(3, 321, 8'd9);
    launch(1'b1);
    wait_done(144, -1, -1);
    set_lanes(99, 1234, 8'd17);
    @(posedge clk);
    set_exp();
    #1;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(144, -1, -1);
    pulse_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
